// File: rtl/harmonic_sum_engine.sv
// Harmonic / alternating-harmonic series accelerator.
// S = sum_{k=1..n} s_k * floor(2^F / k). The controller and the datapath share
// one FSM. Each reciprocal comes from a one-bit-per-cycle restoring divider.
module harmonic_sum_engine #(
  parameter int N_WIDTH   = 5,
  parameter int FRAC_BITS = 16,
  parameter int INT_BITS  = 4,   // must be >= 1 so that 2^F fits in the sum
  localparam int SUM_W    = INT_BITS + FRAC_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_WIDTH-1:0] n,
  input  logic               mode,
  output logic               busy,
  output logic               done,
  output logic [SUM_W-1:0]   sum,
  output logic               overflow
);

  localparam int QW = FRAC_BITS + 1;          // quotient width; 2^F/1 needs the extra MSB
  localparam int CW = $clog2(FRAC_BITS + 2);  // iteration counter 0..F

  typedef enum logic [1:0] {IDLE, DIV, ACC, DONE} state_t;

  state_t             state;
  logic [N_WIDTH-1:0] n_lat;
  logic               mode_lat;
  logic [N_WIDTH-1:0] k;      // current term index, also the divisor
  logic [N_WIDTH-1:0] rem;    // partial remainder, always < k
  logic [QW-1:0]      dq;     // dividend shifts out the top while the quotient shifts in below
  logic [CW-1:0]      cnt;

  localparam logic [QW-1:0] DIVIDEND = {1'b1, {FRAC_BITS{1'b0}}};

  // One restoring-division step plus the signed, saturating accumulate.
  logic [N_WIDTH:0] r_sh, r_sub;
  logic             q_bit;
  logic [SUM_W:0]   q_ext, acc_res;
  logic             acc_sub;

  // Combinational divider step and adder for the current k.
  always_comb begin
    r_sh    = {rem, dq[QW-1]};
    r_sub   = r_sh - {1'b0, k};
    q_bit   = (r_sh >= {1'b0, k});
    q_ext   = {{(SUM_W + 1 - QW){1'b0}}, dq};
    acc_sub = mode_lat & ~k[0];   // even terms are negative in alternating mode
    acc_res = acc_sub ? ({1'b0, sum} - q_ext) : ({1'b0, sum} + q_ext);
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      overflow <= 1'b0;
      n_lat    <= '0;
      mode_lat <= 1'b0;
      k        <= '0;
      rem      <= '0;
      dq       <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            n_lat    <= n;
            mode_lat <= mode;
            sum      <= '0;
            overflow <= 1'b0;
            k        <= N_WIDTH'(1);
            rem      <= '0;
            dq       <= DIVIDEND;
            cnt      <= '0;
            if (n == '0) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= DIV;
              busy  <= 1'b1;
            end
          end
        end
        DIV: begin
          rem <= q_bit ? r_sub[N_WIDTH-1:0] : r_sh[N_WIDTH-1:0];
          dq  <= {dq[QW-2:0], q_bit};
          if (cnt == CW'(FRAC_BITS)) state <= ACC;
          else                       cnt   <= cnt + 1'b1;
        end
        ACC: begin
          // Carry/borrow out of the SUM_W+1 adder selects the clamp.
          if (acc_res[SUM_W]) begin
            if (acc_sub) sum <= '0;
            else begin
              sum      <= '1;
              overflow <= 1'b1;
            end
          end else begin
            sum <= acc_res[SUM_W-1:0];
          end
          if (k == n_lat) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            k     <= k + 1'b1;
            rem   <= '0;
            dq    <= DIVIDEND;
            cnt   <= '0;
            state <= DIV;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_harmonic_sum_engine.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops
// them on every done pulse. Inst 0 uses defaults, inst 1 has INT_BITS=1.
module tb_harmonic_sum_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [4:0]  n0 = '0, n1 = '0;
  logic        mode0 = 1'b0, mode1 = 1'b0;
  logic        busy0, busy1, done0, done1, ov0, ov1;
  logic [19:0] sum0;
  logic [16:0] sum1;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic pdone0 = 1'b0, pdone1 = 1'b0;

  typedef struct { int sum; bit ov; int lat; int t0; string tag; } exp_t;
  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  harmonic_sum_engine u0 (
    .clk(clk), .rst(rst), .start(start0), .n(n0), .mode(mode0),
    .busy(busy0), .done(done0), .sum(sum0), .overflow(ov0));

  harmonic_sum_engine #(.INT_BITS(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .n(n1), .mode(mode1),
    .busy(busy1), .done(done1), .sum(sum1), .overflow(ov1));

  // Independent reference: direct integer division, signed running sum.
  function automatic void ref_model(input int nn, input int md, input int sw,
                                     output int s, output bit ov);
    int mx;
    mx = (1 << sw) - 1;
    s = 0; ov = 0;
    for (int kk = 1; kk <= nn; kk++) begin
      if (md == 1 && (kk % 2) == 0) begin
        s = s - (65536 / kk);
        if (s < 0) s = 0;
      end else begin
        s = s + (65536 / kk);
        if (s > mx) begin s = mx; ov = 1; end
      end
    end
  endfunction

  task automatic chk_done(input int idx, input int s, input bit ov);
    exp_t e;
    bit have;
    int lat;
    have = 0;
    if (idx == 0) begin
      if (sb0.size() > 0) begin e = sb0.pop_front(); have = 1; end
    end else begin
      if (sb1.size() > 0) begin e = sb1.pop_front(); have = 1; end
    end
    compared++;
    if (!have) begin
      mismatched++;
      $display("FAIL unexpected_done inst%0d got sum=%0h required no done", idx, s);
    end else begin
      if (s != e.sum || ov != e.ov) begin
        mismatched++;
        $display("FAIL %s result: got sum=%0h ov=%0b required sum=%0h ov=%0b",
                 e.tag, s, ov, e.sum, e.ov);
      end
      lat = cyc - e.t0 - 1;
      compared++;
      if (lat != e.lat) begin
        mismatched++;
        $display("FAIL %s latency: got %0d required %0d", e.tag, lat, e.lat);
      end
    end
  endtask

  // Monitor: scoreboard pops plus handshake invariants.
  always @(negedge clk) begin
    if (!rst) begin
      if (done0) chk_done(0, int'(sum0), ov0);
      if (done1) chk_done(1, int'(sum1), ov1);
      compared++;
      if ((busy0 && done0) || (busy1 && done1)) begin
        mismatched++;
        $display("FAIL busy_and_done: got busy0=%0b done0=%0b busy1=%0b done1=%0b required not both",
                 busy0, done0, busy1, done1);
      end
      compared++;
      if ((done0 && pdone0) || (done1 && pdone1)) begin
        mismatched++;
        $display("FAIL done_pulse_width: got done high two cycles required one");
      end
    end
    pdone0 <= done0;
    pdone1 <= done1;
  end

  task automatic push_exp(input int idx, input int nn, input int es, input bit eo, input string tag);
    exp_t e;
    e.sum = es; e.ov = eo; e.lat = nn * 18; e.t0 = cyc; e.tag = tag;
    if (idx == 0) sb0.push_back(e); else sb1.push_back(e);
  endtask

  function automatic logic is_done(input int idx);
    return (idx == 0) ? done0 : done1;
  endfunction

  function automatic logic is_active(input int idx);
    return (idx == 0) ? (busy0 | done0) : (busy1 | done1);
  endfunction

  // Issue one run at a negedge and wait (bounded) until it has finished.
  task automatic run_op(input int idx, input int nn, input int md, input int es,
                        input bit eo, input string tag);
    int w;
    w = 0;
    while (is_active(idx) && w < 2000) begin @(negedge clk); w++; end
    if (idx == 0) begin n0 = 5'(nn); mode0 = md[0]; start0 = 1'b1; end
    else          begin n1 = 5'(nn); mode1 = md[0]; start1 = 1'b1; end
    push_exp(idx, nn, es, eo, tag);
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    w = 0;
    while (!is_done(idx) && w < 2000) begin @(negedge clk); w++; end
    if (w >= 2000) begin
      compared++; mismatched++;
      $display("FAIL %s timeout: got no done required done", tag);
    end
    @(negedge clk);
  endtask

  initial begin
    int es;
    bit eo;
    int w;
    // 1. reset, then idle with quiet outputs
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      compared++;
      if (busy0 || done0 || ov0 || sum0 != 0) begin
        mismatched++;
        $display("FAIL reset_idle: got busy=%0b done=%0b ov=%0b sum=%0h required all 0",
                 busy0, done0, ov0, sum0);
      end
    end

    // 2. / 3. / 4. directed vectors on defaults
    run_op(0, 3, 0, 32'h1D555, 0, "harm_n3");
    run_op(0, 5, 1, 32'hC888, 0, "alt_n5");
    run_op(0, 3, 1, 32'hD555, 0, "alt_n3");
    run_op(0, 0, 0, 0, 0, "n0");

    // start held high, n/mode wiggled during an n=5 harmonic run
    n0 = 5'd5; mode0 = 1'b0; start0 = 1'b1;
    push_exp(0, 5, 32'h24888, 0, "held_start");
    w = 0;
    do begin
      @(negedge clk);
      n0 = n0 + 5'd3; mode0 = ~mode0;
      w++;
    end while (!done0 && w < 2000);
    start0 = 1'b0;
    if (w >= 2000) begin
      compared++; mismatched++;
      $display("FAIL held_start timeout: got no done required done");
    end
    repeat (3) @(negedge clk);

    // 5. saturation with INT_BITS=1, then a clean run clears overflow
    run_op(1, 4, 0, 32'h1FFFF, 1, "sat_n4");
    run_op(1, 2, 0, 32'h18000, 0, "after_sat_n2");

    // 6. reset in DIV of the k=2 term aborts with no done pulse
    n0 = 5'd3; mode0 = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compared++;
    if (busy0 || done0 || sum0 != 0) begin
      mismatched++;
      $display("FAIL mid_run_reset: got busy=%0b done=%0b sum=%0h required 0/0/0",
               busy0, done0, sum0);
    end
    run_op(0, 1, 0, 32'h10000, 0, "restart_n1");

    // sweep every n in both modes
    for (int m = 0; m < 2; m++)
      for (int nn = 0; nn < 32; nn++) begin
        ref_model(nn, m, 20, es, eo);
        run_op(0, nn, m, es, eo, $sformatf("sweep_n%0d_m%0d", nn, m));
      end

    repeat (3) @(negedge clk);
    compared++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending required 0", sb0.size(), sb1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
